// File: rtl/dac_pkg.sv
// Shared types and defaults for the DAC feed controller and its sample FIFO.
// The RAMP behaviour in dac_feed_ctrl is enabled by defining DAC_FEED_RAMP_EN.
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RAMP  = 2'd3
    } state_e;

    localparam int DAC_BW_DEFAULT    = 14;
    localparam int DAC_DEPTH_DEFAULT = 4;
    localparam int DAC_DIV_W_DEFAULT = 16;
    localparam int DAC_STEP_DEFAULT  = 64;

endpackage

// File: rtl/dac_sample_fifo.sv
// Small synchronous sample FIFO; power-of-two depth so pointers wrap for free.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module dac_sample_fifo
    import dac_pkg::*;
#(
    parameter int BW    = DAC_BW_DEFAULT,
    parameter int DEPTH = DAC_DEPTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic signed [BW-1:0] data_i,
    input  logic                 pop_i,
    output logic signed [BW-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic signed [BW-1:0] mem_q [DEPTH];
    logic signed [BW-1:0] mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_feed_ctrl.sv
// Paces FIFO samples onto a registered DAC word at a programmable period and winds down on disable.
// Define DAC_FEED_RAMP_EN to ramp dac_o to zero by STEP per tick after draining; otherwise it snaps to 0.
module dac_feed_ctrl
    import dac_pkg::*;
#(
    parameter int BW    = DAC_BW_DEFAULT,
    parameter int DEPTH = DAC_DEPTH_DEFAULT,
    parameter int DIV_W = DAC_DIV_W_DEFAULT,
    parameter int STEP  = DAC_STEP_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DIV_W-1:0]     div_i,
    input  logic                 s_valid_i,
    input  logic signed [BW-1:0] s_data_i,
    output logic                 s_ready_o,
    input  logic                 clr_i,
    output logic signed [BW-1:0] dac_o,
    output logic                 tick_o,
    output logic                 underrun_o,
    output logic                 busy_o,
    output state_e               state_o
);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic signed [BW-1:0] dac_q, dac_d;
    logic                 tick_q, tick_d;
    logic                 und_q, und_d;
    logic                 und_new;
    logic                 busy;
    logic                 tick;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic signed [BW-1:0] fifo_data;

`ifdef DAC_FEED_RAMP_EN
    localparam logic signed [BW-1:0] STEP_S = BW'(STEP);

    // Moves one STEP toward zero; anything within one STEP lands exactly on 0.
    function automatic logic signed [BW-1:0] ramp_step(input logic signed [BW-1:0] v);
        if (v > STEP_S) begin
            return v - STEP_S;
        end else if (v < -STEP_S) begin
            return v + STEP_S;
        end else begin
            return '0;
        end
    endfunction
`endif

    // Upstream handshake: a sample transfers on a clk_i edge where s_valid_i and
    // s_ready_o are both high; s_ready_o is simply "FIFO not full" in every state.
    assign s_ready_o = !fifo_full;
    assign fifo_push = s_valid_i && s_ready_o;

    assign busy = (state_q != ST_IDLE);
    assign tick = busy && (cnt_q == '0);

    dac_sample_fifo #(
        .BW    (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (s_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Period divider: free-runs while busy, reloads on IDLE->RUN and after each tick.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            if (en_i) begin
                cnt_d = div_i;
            end
        end else if (tick) begin
            cnt_d = div_i;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        dac_d    = dac_q;
        tick_d   = tick;
        und_new  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        dac_d    = fifo_data;
                    end else begin
                        und_new = 1'b1;
                    end
                end
                if (!en_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tick && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    dac_d    = fifo_data;
                end
                if (en_i) begin
                    state_d = ST_RUN;
                end else if (tick && fifo_empty) begin
`ifdef DAC_FEED_RAMP_EN
                    state_d = ST_RAMP;
`else
                    state_d = ST_IDLE;
                    dac_d   = '0;
`endif
                end
            end
            ST_RAMP: begin
`ifdef DAC_FEED_RAMP_EN
                if (en_i) begin
                    state_d = ST_RUN;
                end else if (dac_q == '0) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    dac_d = ramp_step(dac_q);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh underrun wins over a simultaneous clear.
        und_d = (und_q && !clr_i) || und_new;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dac_q   <= '0;
            tick_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dac_q   <= dac_d;
            tick_q  <= tick_d;
            und_q   <= und_d;
        end
    end

    assign dac_o      = dac_q;
    assign tick_o     = tick_q;
    assign underrun_o = und_q;
    assign busy_o     = busy;
    assign state_o    = state_q;

endmodule

// File: tb/tb_dac_feed_ctrl.sv
// Directed bench for dac_feed_ctrl: a cycle-group vector table plus hand-written corner sequences.
// Expectations follow DAC_FEED_RAMP_EN when it is defined for the build.
module tb_dac_feed_ctrl;
    import dac_pkg::*;

    localparam int BW    = 14;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int STEP  = 64;
    localparam int NV    = 23;

    logic                 clk;
    logic                 rst_ni;
    logic                 en_i;
    logic [DIV_W-1:0]     div_i;
    logic                 s_valid_i;
    logic signed [BW-1:0] s_data_i;
    logic                 s_ready_o;
    logic                 clr_i;
    logic signed [BW-1:0] dac_o;
    logic                 tick_o;
    logic                 underrun_o;
    logic                 busy_o;
    state_e               state_o;

    int total;
    int bad;

    typedef struct {
        logic en;
        logic v;
        int   data;
        logic clr;
        int   n;
        int   e_dac;
        logic e_tick;
        logic e_und;
        logic e_busy;
        logic e_rdy;
    } vec_t;

    vec_t vt [NV];

    dac_feed_ctrl #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .DIV_W (DIV_W),
        .STEP  (STEP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .div_i      (div_i),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .s_ready_o  (s_ready_o),
        .clr_i      (clr_i),
        .dac_o      (dac_o),
        .tick_o     (tick_o),
        .underrun_o (underrun_o),
        .busy_o     (busy_o),
        .state_o    (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic en, input logic v, input int data, input logic clr,
                                input int n, input int e_dac, input logic e_tick, input logic e_und,
                                input logic e_busy, input logic e_rdy);
        vec_t r;
        r.en = en; r.v = v; r.data = data; r.clr = clr; r.n = n;
        r.e_dac = e_dac; r.e_tick = e_tick; r.e_und = e_und; r.e_busy = e_busy; r.e_rdy = e_rdy;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance n rising edges and park on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input int e_dac, input logic e_tick, input logic e_und,
                           input logic e_busy, input logic e_rdy);
        chk({nm, "_dac"}, int'(dac_o), e_dac);
        chk({nm, "_tick"}, int'(tick_o), int'(e_tick));
        chk({nm, "_und"}, int'(underrun_o), int'(e_und));
        chk({nm, "_busy"}, int'(busy_o), int'(e_busy));
        chk({nm, "_rdy"}, int'(s_ready_o), int'(e_rdy));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Fill then run at div=3, underrun and clear, then wind down with an empty FIFO.
        vt[0]  = mk(0, 1,  100, 0, 1,    0, 0, 0, 0, 1);
        vt[1]  = mk(0, 1, -200, 0, 1,    0, 0, 0, 0, 1);
        vt[2]  = mk(0, 1,  300, 0, 1,    0, 0, 0, 0, 1);
        vt[3]  = mk(0, 1,  400, 0, 1,    0, 0, 0, 0, 0);
        vt[4]  = mk(0, 1,  500, 0, 1,    0, 0, 0, 0, 0);
        vt[5]  = mk(1, 0,    0, 0, 1,    0, 0, 0, 1, 0);
        vt[6]  = mk(1, 0,    0, 0, 3,    0, 0, 0, 1, 0);
        vt[7]  = mk(1, 0,    0, 0, 1,  100, 1, 0, 1, 1);
        vt[8]  = mk(1, 0,    0, 0, 3,  100, 0, 0, 1, 1);
        vt[9]  = mk(1, 0,    0, 0, 1, -200, 1, 0, 1, 1);
        vt[10] = mk(1, 0,    0, 0, 4,  300, 1, 0, 1, 1);
        vt[11] = mk(1, 0,    0, 0, 4,  400, 1, 0, 1, 1);
        vt[12] = mk(1, 0,    0, 0, 4,  400, 1, 1, 1, 1);
        vt[13] = mk(1, 0,    0, 1, 1,  400, 0, 0, 1, 1);
        vt[14] = mk(1, 0,    0, 0, 3,  400, 1, 1, 1, 1);
        vt[15] = mk(1, 1,  150, 1, 1,  400, 0, 0, 1, 1);
        vt[16] = mk(1, 0,    0, 0, 3,  150, 1, 0, 1, 1);
        vt[17] = mk(0, 0,    0, 0, 1,  150, 0, 0, 1, 1);
`ifdef DAC_FEED_RAMP_EN
        vt[18] = mk(0, 0,    0, 0, 3,  150, 1, 0, 1, 1);
        vt[19] = mk(0, 0,    0, 0, 4,   86, 1, 0, 1, 1);
        vt[20] = mk(0, 0,    0, 0, 4,   22, 1, 0, 1, 1);
        vt[21] = mk(0, 0,    0, 0, 4,    0, 1, 0, 1, 1);
        vt[22] = mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1);
`else
        vt[18] = mk(0, 0,    0, 0, 3,    0, 1, 0, 0, 1);
        vt[19] = mk(0, 0,    0, 0, 4,    0, 0, 0, 0, 1);
        vt[20] = mk(0, 0,    0, 0, 4,    0, 0, 0, 0, 1);
        vt[21] = mk(0, 0,    0, 0, 4,    0, 0, 0, 0, 1);
        vt[22] = mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1);
`endif

        rst_ni    = 1'b0;
        en_i      = 1'b0;
        div_i     = DIV_W'(3);
        s_valid_i = 1'b0;
        s_data_i  = '0;
        clr_i     = 1'b0;
        cyc(2);
        chk_out("reset", 0, 0, 0, 0, 1);
        chk("reset_state", int'(state_o), int'(ST_IDLE));
        rst_ni = 1'b1;
        cyc(1);

        for (int i = 0; i < NV; i++) begin
            en_i      = vt[i].en;
            s_valid_i = vt[i].v;
            s_data_i  = BW'(vt[i].data);
            clr_i     = vt[i].clr;
            cyc(1);
            s_valid_i = 1'b0;
            clr_i     = 1'b0;
            if (vt[i].n > 1) cyc(vt[i].n - 1);
            chk_out($sformatf("row%0d", i), vt[i].e_dac, vt[i].e_tick, vt[i].e_und,
                    vt[i].e_busy, vt[i].e_rdy);
        end
        chk("wind_down_state", int'(state_o), int'(ST_IDLE));

        // Reset mid-RUN with three samples still queued.
        for (int i = 1; i <= 4; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = BW'(i * 10);
            cyc(1);
        end
        s_valid_i = 1'b0;
        en_i      = 1'b1;
        cyc(1);
        cyc(4);
        chk_out("pre_rst", 10, 1, 0, 1, 1);
        rst_ni = 1'b0;
        en_i   = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 1);
        chk("async_rst_state", int'(state_o), int'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        en_i   = 1'b1;
        cyc(1);
        cyc(4);
        chk_out("post_rst_underrun", 0, 1, 1, 1, 1);

        // Push on the same edge as an underrun tick: flag sets, sample survives.
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        chk("clr_und", int'(underrun_o), 0);
        cyc(2);
        s_valid_i = 1'b1;
        s_data_i  = BW'(77);
        cyc(1);
        s_valid_i = 1'b0;
        chk_out("push_tick_empty", 0, 1, 1, 1, 1);
        cyc(4);
        chk_out("retained_sample", 77, 1, 1, 1, 1);

        // Clear and a new underrun on the same edge: the flag stays set.
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        chk("clr_und2", int'(underrun_o), 0);
        cyc(2);
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        chk_out("clr_vs_underrun", 77, 1, 1, 1, 1);

        // Re-enable while draining returns to RUN without touching dac_o.
        en_i  = 1'b0;
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        chk("drain_state", int'(state_o), int'(ST_DRAIN));
        en_i = 1'b1;
        cyc(1);
        chk("reenable_state", int'(state_o), int'(ST_RUN));
        chk("reenable_dac", int'(dac_o), 77);
        cyc(2);
        chk_out("reenable_tick", 77, 1, 1, 1, 1);
        chk("reenable_tick_state", int'(state_o), int'(ST_RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
